// File: rtl/pc_gen_pkg.sv
// Shared fetch-stage definitions: PC generator state encoding and the default
// PC geometry and vectors reused by the fetch, decode and exception blocks.
package pc_gen_pkg;

    // Program-counter generator sequencing state.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

    // Default PC geometry and vectors.
    localparam int unsigned DEFAULT_XLEN        = 32;
    localparam int unsigned DEFAULT_INSTR_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

endpackage : pc_gen_pkg

// File: rtl/pc_redirect_buffer.sv
// Single-entry pending-redirect register.
// Holds a redirect target that arrived while fetch was stalled until the
// stall releases. A set while an entry is held overwrites it; clear wins
// over set.
//
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   set             capture set_target and mark the entry valid
//   clear           invalidate the entry
//   set_target      target to capture (already aligned by the caller)
//   pending_valid   an entry is held
//   pending_target  the held target
module pc_redirect_buffer
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            set,
    input  logic            clear,
    input  logic [XLEN-1:0] set_target,
    output logic            pending_valid,
    output logic [XLEN-1:0] pending_target
);

    // Entry register; the target is left untouched on clear since it is
    // meaningless without the valid flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_valid  <= 1'b0;
            pending_target <= '0;
        end else if (clear) begin
            pending_valid  <= 1'b0;
        end else if (set) begin
            pending_valid  <= 1'b1;
            pending_target <= set_target;
        end
    end

endmodule : pc_redirect_buffer

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator.
// Holds the architectural fetch PC, advances it by one instruction per
// clock, and supports stall, branch/jump redirect (buffered when it arrives
// during a stall), exception vectoring, and a one-cycle boot after reset.
//
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   stall             hold the PC this cycle
//   redirect_valid    branch/jump taken this cycle
//   redirect_target   redirect destination (low bits are aligned away)
//   exc_valid         exception/flush request, overrides stall and redirect
//   pc                current fetch PC (registered)
//   pc_plus           pc + INSTR_BYTES (combinational)
//   fetch_valid       pc is a valid fetch address this cycle
//   redirect_pending  a buffered redirect is waiting for the stall to clear
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN         = DEFAULT_XLEN,
    parameter int unsigned     INSTR_BYTES  = DEFAULT_INSTR_BYTES,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(DEFAULT_EXC_VECTOR)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            exc_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            fetch_valid,
    output logic            redirect_pending
);

    // Clears the instruction-offset bits; all ones when INSTR_BYTES is 1.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES) - XLEN'(1));

    pc_state_e       state_q;
    pc_state_e       state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            buf_set;
    logic            buf_clear;
    logic [XLEN-1:0] redirect_aligned;
    logic            pending_valid;
    logic [XLEN-1:0] pending_target;

    assign redirect_aligned = redirect_target & ALIGN_MASK;

    // Pending redirect captured during a stall.
    pc_redirect_buffer #(
        .XLEN (XLEN)
    ) u_redirect_buffer (
        .clk            (clk),
        .reset_n        (reset_n),
        .set            (buf_set),
        .clear          (buf_clear),
        .set_target     (redirect_aligned),
        .pending_valid  (pending_valid),
        .pending_target (pending_target)
    );

    // State and PC registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state and PC update; first matching rule wins in RUN.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_set   = 1'b0;
        buf_clear = 1'b0;
        case (state_q)
            BOOT: begin
                // Inputs are ignored for the boot cycle.
                state_d = RUN;
            end
            RUN: begin
                if (exc_valid) begin
                    pc_d      = EXC_VECTOR;
                    buf_clear = 1'b1;
                end else if (redirect_valid && !stall) begin
                    pc_d      = redirect_aligned;
                    buf_clear = 1'b1;
                end else if (redirect_valid) begin
                    // Newest redirect replaces any older pending entry.
                    buf_set   = 1'b1;
                end else if (stall) begin
                    pc_d      = pc_q;
                end else if (pending_valid) begin
                    pc_d      = pending_target & ALIGN_MASK;
                    buf_clear = 1'b1;
                end else begin
                    pc_d      = pc_plus;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Sequential next PC; wraps modulo 2^XLEN.
    assign pc_plus          = pc_q + XLEN'(INSTR_BYTES);
    assign pc               = pc_q;
    // The PC is not a useful fetch address while a redirect is waiting.
    assign fetch_valid      = (state_q == RUN) && !pending_valid;
    assign redirect_pending = pending_valid;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the PC rules.
module tb_pc_gen;

    localparam int unsigned XLEN = 32;
    localparam int unsigned IB   = 4;
    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] EV   = 32'h0000_0080;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        fetch_valid;
    logic        redirect_pending;

    int checks;
    int failures;

    // Reference model state
    bit          m_run;
    logic [31:0] m_pc;
    bit          m_pv;
    logic [31:0] m_pt;

    pc_gen #(
        .XLEN         (XLEN),
        .INSTR_BYTES  (IB),
        .RESET_VECTOR (RV),
        .EXC_VECTOR   (EV)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .exc_valid        (exc_valid),
        .pc               (pc),
        .pc_plus          (pc_plus),
        .fetch_valid      (fetch_valid),
        .redirect_pending (redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] t);
        return (t / IB) * IB;
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_pc  = RV;
        m_pv  = 0;
        m_pt  = '0;
    endtask

    // One clock of the architectural rules.
    task automatic model_clock(input bit s, input bit rv, input logic [31:0] rt, input bit ex);
        if (!m_run) begin
            m_run = 1;
        end else if (ex) begin
            m_pc = EV;
            m_pv = 0;
        end else if (rv && !s) begin
            m_pc = align(rt);
            m_pv = 0;
        end else if (rv) begin
            m_pv = 1;
            m_pt = align(rt);
        end else if (!s) begin
            if (m_pv) begin
                m_pc = m_pt;
                m_pv = 0;
            end else begin
                m_pc = m_pc + IB;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pc_plus"}, pc_plus, m_pc + IB);
        check({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(m_run && !m_pv));
        check({tag, ".pending"}, 32'(redirect_pending), 32'(m_pv));
    endtask

    // Drive one cycle of inputs, clock, then compare against the model.
    task automatic step(input string tag, input bit s, input bit rv,
                        input logic [31:0] rt, input bit ex);
        stall           = s;
        redirect_valid  = rv;
        redirect_target = rt;
        exc_valid       = ex;
        model_clock(s, rv, rt, ex);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Asynchronous reset between edges, checked before any clock.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs({tag, ".in_reset"});
        #1;
        reset_n = 1'b1;
        #1;
        check_outputs({tag, ".released"});
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset_n         = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        exc_valid       = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        check("reset.pc_plus_const", pc_plus, 32'h4);
        reset_n = 1'b1;
        #1;
        check("cycle0.pc", pc, 32'h0);
        check("cycle0.fv", 32'(fetch_valid), 32'h0);

        // Exception during BOOT is ignored.
        step("boot_exc", 1'b0, 1'b0, 32'h0, 1'b1);
        check("boot_exc.pc_const", pc, 32'h0);
        check("cycle1.fv_const", 32'(fetch_valid), 32'h1);
        idle("run4");
        check("run4.pc_const", pc, 32'h4);
        idle("run8");
        idle("runC");
        idle("run10");
        check("run10.pc_const", pc, 32'h10);

        // Stall hold.
        for (int i = 0; i < 3; i++) step("stall_hold", 1'b1, 1'b0, 32'h0, 1'b0);
        check("stall_hold.pc_const", pc, 32'h10);
        idle("after_stall");
        check("after_stall.pc_const", pc, 32'h14);
        idle("run18");
        idle("run1C");
        idle("run20");

        // Redirect during stall, overwritten, then released.
        step("stall_redir1", 1'b1, 1'b1, 32'h400, 1'b0);
        check("stall_redir1.pending_const", 32'(redirect_pending), 32'h1);
        check("stall_redir1.fv_const", 32'(fetch_valid), 32'h0);
        step("stall_redir2", 1'b1, 1'b1, 32'h500, 1'b0);
        idle("release");
        check("release.pc_const", pc, 32'h500);
        idle("release_next");
        check("release_next.pc_const", pc, 32'h504);

        // Exception beats redirect, stall and a pending entry.
        step("pend_for_exc", 1'b1, 1'b1, 32'h600, 1'b0);
        step("exc_prio", 1'b1, 1'b1, 32'h300, 1'b1);
        check("exc_prio.pc_const", pc, 32'h80);
        check("exc_prio.pending_const", 32'(redirect_pending), 32'h0);

        // Masking and wrap.
        step("mask", 1'b0, 1'b1, 32'h1237, 1'b0);
        check("mask.pc_const", pc, 32'h1234);
        step("to_top", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        idle("wrap");
        check("wrap.pc_const", pc, 32'h0);
        check("wrap.pc_plus_const", pc_plus, 32'h4);

        // Async reset with a pending redirect.
        step("pend_for_rst", 1'b1, 1'b1, 32'h700, 1'b0);
        async_reset("mid_rst");
        check("mid_rst.pending_const", 32'(redirect_pending), 32'h0);

        // Random phase.
        for (int i = 0; i < 600; i++) begin
            bit          s;
            bit          rv;
            bit          ex;
            logic [31:0] rt;
            s  = ($urandom_range(0, 99) < 40);
            rv = ($urandom_range(0, 99) < 30);
            ex = ($urandom_range(0, 99) < 6);
            rt = $urandom();
            if ($urandom_range(0, 7) == 0) rt = 32'hFFFF_FFF0 | (rt & 32'hF);
            if ($urandom_range(0, 79) == 0) async_reset("rand_rst");
            else step("rand", s, rv, rt, ex);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_gen
